// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM: a 4-bit state register plus decode of the
// per-state datapath controls, with ALU function decoding for R-type instructions.
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       iord,
  output logic       alusrca,
  output logic       pcen,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e state_q, state_d;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = StFetch;
    alucontrol = 3'b000;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        alusrcb    = 2'b01;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        alucontrol = AluAdd;
        state_d    = StDecode;
      end
      StDecode: begin
        alusrcb    = 2'b11;
        alucontrol = AluAdd;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default: begin
            // Unsupported opcode: flag it and retire with no side effects.
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = AluAdd;
        state_d    = (op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StExecute: begin
        alusrca = 1'b1;
        state_d = StAluWb;
        case (funct)
          6'b100000: alucontrol = AluAdd;
          6'b100010: alucontrol = AluSub;
          6'b100100: alucontrol = AluAnd;
          6'b100101: alucontrol = AluOr;
          6'b101010: alucontrol = AluSlt;
          default:   alucontrol = AluAdd;
        endcase
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBranch: begin
        alusrca    = 1'b1;
        alucontrol = AluSub;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      StAddiExec: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = AluAdd;
        state_d    = StAddiWb;
      end
      StAddiWb: begin
        regwrite = 1'b1;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    pcen = pcwrite | (branch & zero);
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, reset corner cases,
// and randomized instruction streams checked against an instruction-level model.
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       memwrite, irwrite, regwrite, regdst, memtoreg, iord, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] state;
  logic       illegal;

  mc_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .alucontrol(alucontrol),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .iord      (iord),
    .alusrca   (alusrca),
    .pcen      (pcen),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .state     (state),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-state control values as listed in the state table.
  typedef struct packed {
    logic [2:0] alu;
    logic       mw, irw, rw, rd, m2r, iord, asa, pcw, br;
    logic [1:0] asb, pcs;
  } out_t;

  out_t exp_tab [16];

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         lat;
    logic [2:0] exec_alu;
  } vec_t;

  typedef int iq_t[$];

  function automatic out_t mk(input logic [2:0] alu, input logic mw, irw, rw, rd, m2r, io,
                              asa, pcw, br, input logic [1:0] asb, pcs);
    out_t o;
    o = {alu, mw, irw, rw, rd, m2r, io, asa, pcw, br, asb, pcs};
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] exec_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Sequence of states an instruction visits, starting at FETCH.
  function automatic iq_t path(input logic [5:0] o);
    iq_t q;
    case (o)
      6'b100011: q = {0, 1, 2, 3, 4};
      6'b101011: q = {0, 1, 2, 5};
      6'b000000: q = {0, 1, 6, 7};
      6'b000100: q = {0, 1, 8};
      6'b001000: q = {0, 1, 9, 10};
      6'b000010: q = {0, 1, 11};
      default:   q = {0, 1};
    endcase
    return q;
  endfunction

  function automatic logic [15:0] expect_vec(input int st, input logic [5:0] o,
                                             input logic [5:0] f, input logic z);
    out_t       e;
    logic [2:0] alu;
    logic       ill;
    logic       pe;
    e   = exp_tab[st];
    alu = (st == 6) ? exec_alu(f) : e.alu;
    ill = (st == 1) && !is_legal(o);
    pe  = e.pcw | (e.br & z);
    return {alu, e.mw, e.irw, e.rw, e.rd, e.m2r, e.iord, e.asa, pe, e.asb, e.pcs, ill};
  endfunction

  function automatic logic [15:0] actual_vec();
    return {alucontrol, memwrite, irwrite, regwrite, regdst, memtoreg, iord, alusrca, pcen,
            alusrcb, pcsrc, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH, checking every cycle; returns measured latency.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input bit rnd, output int lat);
    iq_t q;
    int  st;
    q   = path(o);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < q.size()) begin
        st = q[k];
        // op/funct only matter in DECODE, MEMADR, EXECUTE; scramble them elsewhere.
        if (rnd && !(st inside {1, 2, 6})) begin
          op    = 6'($urandom);
          funct = 6'($urandom);
        end else begin
          op    = o;
          funct = f;
        end
        zero = rnd ? 1'($urandom) : z;
        #1;
        check($sformatf("state op=%b k=%0d", o, k), 32'(state), 32'(st));
        check($sformatf("outputs op=%b st=%0d", o, st), 32'(actual_vec()),
              32'(expect_vec(st, op, funct, zero)));
      end
      step();
      lat = k + 1;
      if (state == 4'd0) break;
    end
  endtask

  vec_t vecs [$];

  initial begin
    int lat;
    int r;
    logic [5:0] ro, rf;
    logic [5:0] ops [6];
    logic [5:0] fns [5];

    exp_tab[0]  = mk(3'b010, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00);
    exp_tab[1]  = mk(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00);
    exp_tab[2]  = mk(3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00);
    exp_tab[3]  = mk(3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    exp_tab[4]  = mk(3'b000, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_tab[5]  = mk(3'b000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    exp_tab[6]  = mk(3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    exp_tab[7]  = mk(3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_tab[8]  = mk(3'b110, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b01);
    exp_tab[9]  = mk(3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00);
    exp_tab[10] = mk(3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_tab[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10);
    for (int i = 12; i < 16; i++) exp_tab[i] = '0;

    vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, 3'b000});
    vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, 3'b000});
    vecs.push_back('{6'b000000, 6'b100010, 1'b0, 4, 3'b110});
    vecs.push_back('{6'b000000, 6'b101010, 1'b0, 4, 3'b111});
    vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, 3'b010});
    vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, 3'b000});
    vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, 3'b001});
    vecs.push_back('{6'b000000, 6'b000111, 1'b0, 4, 3'b010});
    vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, 3'b000});
    vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, 3'b000});
    vecs.push_back('{6'b001000, 6'b000000, 1'b0, 4, 3'b000});
    vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, 3'b000});
    vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, 3'b000});
    vecs.push_back('{6'b000001, 6'b100000, 1'b0, 2, 3'b000});

    // Reset held low for two cycles, then released.
    reset_n = 1'b0;
    op      = 6'b111111;
    funct   = 6'b0;
    zero    = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset outputs", 32'(actual_vec()), 32'(expect_vec(0, op, funct, zero)));
    check("reset irwrite/pcen/memwrite", {29'd0, irwrite, pcen, memwrite}, 32'b110);
    check("reset alusrcb/alucontrol", {27'd0, alusrcb, alucontrol}, {27'd0, 2'b01, 3'b010});

    // Directed table.
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, 1'b0, lat);
      check($sformatf("latency op=%b funct=%b", vecs[i].op, vecs[i].funct), 32'(lat),
            32'(vecs[i].lat));
      if (vecs[i].op == 6'b000000) begin
        check($sformatf("exec alu funct=%b", vecs[i].funct), 32'(exec_alu(vecs[i].funct)),
              32'(vecs[i].exec_alu));
      end
    end

    // Reset while in MEMWR: store must not repeat afterwards.
    op = 6'b101011;
    funct = 6'b0;
    zero = 1'b0;
    repeat (3) step();
    check("sw reaches MEMWR", 32'(state), 32'd5);
    check("memwrite in MEMWR", 32'(memwrite), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    check("reset in MEMWR -> FETCH", 32'(state), 32'd0);
    op = 6'b111111;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("memwrite after reset k=%0d", k), 32'(memwrite), 32'd0);
      check($sformatf("regwrite after reset k=%0d", k), 32'(regwrite), 32'd0);
      step();
    end
    check("state after illegal loop", 32'(state), 32'd0);

    // Reset while in ALUWB: register write must not repeat.
    op = 6'b000000;
    funct = 6'b100000;
    repeat (3) step();
    check("R-type reaches ALUWB", 32'(state), 32'd7);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    op = 6'b111111;
    #1;
    check("reset in ALUWB -> FETCH", 32'(state), 32'd0);
    check("regwrite after ALUWB reset", 32'(regwrite), 32'd0);
    step();
    check("regwrite after ALUWB reset +1", 32'(regwrite), 32'd0);
    step();
    check("state after ALUWB reset +2", 32'(state), 32'd0);

    // Randomized instruction stream.
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom_range(0, 7));
      ro = (r < 6) ? ops[r] : 6'($urandom);
      r  = int'($urandom_range(0, 5));
      rf = (r < 5) ? fns[r] : 6'($urandom);
      run_instr(ro, rf, 1'b0, 1'b1, lat);
      check($sformatf("rand latency op=%b", ro), 32'(lat), 32'(path(ro).size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
